// File: rtl/char_ram_writer.sv
// Write-side front end for the character display RAM: ASCII valid/ready stream in, cursor-addressed writes out.
// Optional build macro CHAR_WRITER_AUTO_CLEAR_EN: run one clear sweep automatically after reset release.
module char_ram_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter int         ADDR_WIDTH = 12,
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  localparam int        COL_W      = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int        ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  input  logic                  clr_req,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [COL_W-1:0]      cur_col,
  output logic [ROW_W-1:0]      cur_row,
  output logic                  busy,
  output logic                  dbg_state
);

  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [DATA_WIDTH-1:0] CLR_WORD  = DATA_WIDTH'(CLEAR_CHAR);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
  logic                    clr_go, accept, printable, line_adv;

`ifdef CHAR_WRITER_AUTO_CLEAR_EN
  logic auto_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_q <= 1'b1;
    else        auto_q <= 1'b0;
  end
  assign clr_go = clr_req | auto_q;
`else
  assign clr_go = clr_req;
`endif

  // Handshake: a byte transfers on a rising edge where s_valid & s_ready; s_ready never depends on s_valid.
  assign s_ready   = (state_q == S_IDLE) & ~clr_go;
  assign accept    = s_valid & s_ready;
  assign printable = (s_data >= 8'h20) && (s_data <= 8'h7E);

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    line_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_go || (accept && s_data == 8'h0C)) begin
          state_d = S_CLEAR;
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = CLR_WORD;
        end else if (accept) begin
          if (printable) begin
            we_d    = 1'b1;
            waddr_d = row_base_q + ADDR_WIDTH'(col_q);
            wdata_d = DATA_WIDTH'(s_data);
            if (col_q == COL_LAST) begin
              col_d    = '0;
              line_adv = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            case (s_data)
              8'h0A: begin
                col_d    = '0;
                line_adv = 1'b1;
              end
              8'h0D: col_d = '0;
              8'h08: if (col_q != '0) col_d = col_q - COL_W'(1);
              default: ;
            endcase
          end
          // Row base tracks row*COLS incrementally so the address path needs no multiplier.
          if (line_adv) begin
            if (row_q == ROW_LAST) begin
              row_d      = '0;
              row_base_d = '0;
            end else begin
              row_d      = row_q + ROW_W'(1);
              row_base_d = row_base_q + ROW_STEP;
            end
          end
        end
      end
      S_CLEAR: begin
        if (waddr_q == ADDR_LAST) begin
          state_d    = S_IDLE;
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign cur_col   = col_q;
  assign cur_row   = row_q;
  assign busy      = (state_q == S_CLEAR);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_char_ram_writer.sv
// Bench for char_ram_writer on a 4x2 screen: cursor/screen model checked every cycle plus directed literal checks.
module tb_char_ram_writer;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int NCELL = COLS * ROWS;
`ifdef CHAR_WRITER_AUTO_CLEAR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // clock / reset / inputs
  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data  = 8'h00;
  logic          clr_req = 1'b0;
  logic          s_ready, we, busy, dbg_state;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [1:0]    cur_col;
  logic [0:0]    cur_row;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  char_ram_writer #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_CHAR(8'h20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .clr_req(clr_req), .we(we), .waddr(waddr), .wdata(wdata), .cur_col(cur_col),
    .cur_row(cur_row), .busy(busy), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: cursor as (col,row) integers, screen address = row*COLS+col
  int         m_col = 0, m_row = 0, m_next = 0, m_waddr = 0;
  bit         m_busy = 1'b0, m_we = 1'b0, m_auto = AUTO;
  logic [7:0] m_wdata = 8'h00;

  task automatic model_reset();
    m_col = 0; m_row = 0; m_next = 0; m_waddr = 0;
    m_busy = 1'b0; m_we = 1'b0; m_auto = AUTO; m_wdata = 8'h00;
  endtask

  task automatic model_start_clear();
    m_busy = 1'b1; m_we = 1'b1; m_waddr = 0; m_wdata = 8'h20; m_next = 1;
  endtask

  task automatic model_step();
    bit go;
    go     = clr_req || m_auto;
    m_auto = 1'b0;
    m_we   = 1'b0;
    if (m_busy) begin
      if (m_next < NCELL) begin
        m_we = 1'b1; m_waddr = m_next; m_next++;
      end else begin
        m_busy = 1'b0; m_col = 0; m_row = 0;
      end
    end else if (go) begin
      model_start_clear();
    end else if (s_valid) begin
      if (s_data >= 8'h20 && s_data <= 8'h7E) begin
        m_we = 1'b1; m_waddr = m_row * COLS + m_col; m_wdata = s_data;
        if (m_col < COLS - 1) m_col++;
        else begin m_col = 0; m_row = (m_row + 1) % ROWS; end
      end else if (s_data == 8'h0A) begin
        m_col = 0; m_row = (m_row + 1) % ROWS;
      end else if (s_data == 8'h0D) begin
        m_col = 0;
      end else if (s_data == 8'h08) begin
        if (m_col > 0) m_col--;
      end else if (s_data == 8'h0C) begin
        model_start_clear();
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  // per-cycle compare, mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_we", we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_col", cur_col, 0);
      chk("rst_row", cur_row, 0);
    end else begin
      chk("s_ready", s_ready, (!m_busy && !clr_req && !m_auto));
      chk("we", we, m_we);
      chk("busy", busy, m_busy);
      if (m_we) begin
        chk("waddr", waddr, m_waddr);
        chk("wdata", wdata, m_wdata);
      end
      if (!m_busy) begin
        chk("cur_col", cur_col, m_col);
        chk("cur_row", cur_row, m_row);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((m_busy || m_auto || busy) && guard < 4 * NCELL + 10) begin
      tick();
      guard++;
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("lit_reset_we", we, 0);
    chk("lit_reset_busy", busy, 0);
    chk("lit_reset_cursor", {cur_row, cur_col}, 0);
    rst_n = 1'b1;
    wait_idle();

    // single printable byte
    send(8'h41);
    chk("lit_a_we", we, 1);
    chk("lit_a_waddr", waddr, 0);
    chk("lit_a_wdata", wdata, 8'h41);
    chk("lit_a_col", cur_col, 1);
    chk("lit_a_row", cur_row, 0);

    // nine back-to-back bytes, ninth wraps to address 0
    apply_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_data = 8'h41 + 8'(i);
      #1;
      chk("lit_burst_ready", s_ready, 1);
      tick();
      chk("lit_burst_we", we, 1);
      chk("lit_burst_waddr", waddr, i % 8);
      chk("lit_burst_wdata", wdata, 8'h41 + i);
    end
    s_valid = 1'b0;
    tick();
    chk("lit_burst_we_drop", we, 0);

    // LF then printable on row 1
    apply_reset();
    send(8'h41);
    send(8'h42);
    send(8'h0A);
    chk("lit_lf_we", we, 0);
    chk("lit_lf_cursor", {cur_row, cur_col}, 3'b100);
    send(8'h42);
    chk("lit_lf_waddr", waddr, 4);
    chk("lit_lf_col", cur_col, 1);

    // BS at column 0 and 3, CR, discarded bytes, LF wrap, printable range edges
    apply_reset();
    send(8'h08);
    chk("lit_bs0_we", we, 0);
    chk("lit_bs0_col", cur_col, 0);
    send(8'h41); send(8'h42); send(8'h43);
    send(8'h08);
    chk("lit_bs3_we", we, 0);
    chk("lit_bs3_col", cur_col, 2);
    send(8'h0D);
    chk("lit_cr_col", cur_col, 0);
    send(8'h01);
    chk("lit_ctl_we", we, 0);
    send(8'h0A);
    chk("lit_lf1_row", cur_row, 1);
    send(8'h0A);
    chk("lit_lf_wrap_row", cur_row, 0);
    send(8'h7F);
    chk("lit_7f_we", we, 0);
    send(8'h7E);
    chk("lit_7e_wdata", wdata, 8'h7E);
    send(8'h1F);
    chk("lit_1f_col", cur_col, 1);
    send(8'h20);
    chk("lit_20_waddr", waddr, 1);

    // clear beats a coincident byte; clr_req and bytes during the sweep are ignored
    send(8'h41);
    clr_req = 1'b1; s_valid = 1'b1; s_data = 8'h41;
    #1;
    chk("lit_clr_ready", s_ready, 0);
    tick();
    clr_req = 1'b0; s_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("lit_clr_we", we, 1);
      chk("lit_clr_waddr", waddr, k);
      chk("lit_clr_wdata", wdata, 8'h20);
      chk("lit_clr_busy", busy, 1);
      clr_req = (k == 3);
      s_valid = (k == 5);
      s_data  = 8'h55;
      tick();
    end
    clr_req = 1'b0; s_valid = 1'b0;
    chk("lit_clr_done_busy", busy, 0);
    chk("lit_clr_done_we", we, 0);
    chk("lit_clr_done_cursor", {cur_row, cur_col}, 0);

    // form feed starts the same sweep
    send(8'h41);
    send(8'h0C);
    chk("lit_ff_busy", busy, 1);
    chk("lit_ff_waddr", waddr, 0);
    wait_idle();

    // reset during the fourth sweep cycle
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick(); tick();
    chk("lit_mid_waddr", waddr, 3);
    rst_n = 1'b0;
    #1;
    chk("lit_mid_rst_we", we, 0);
    chk("lit_mid_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("lit_post_rst_busy", busy, AUTO);
    chk("lit_post_rst_we", we, AUTO);
    wait_idle();
    send(8'h5A);
    chk("lit_final_waddr", waddr, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
